paint_ctrl_brush: RTL

//  Parametrised retro_paint controller FSM: samples cursor position, decodes key strobes, runs cursor/palette
//  sub-engines via level enables, and paints a square brush (1..BRUSH_MAX px side) clipped to the canvas.

---
 rtl/paint_ctrl_brush.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/paint_ctrl_brush.sv
// paint_ctrl_brush: retro_paint controller. Samples the cursor, decodes latched
// key strobes, runs the cursor/palette drawers through level enables, and paints
// a square brush clipped to the canvas. Pixel writes go out over a valid/ready port.
module paint_ctrl_brush #(
  parameter int            XW        = 8,
  parameter int            YW        = 8,
  parameter int            CW        = 8,
  parameter int            PAL_XW    = 4,
  parameter int            CANVAS_W  = 64,
  parameter int            CANVAS_H  = 64,
  parameter int            BRUSH_MAX = 4,
  parameter logic [CW-1:0] DEF_COLOR = 8'h0F,
  parameter logic [CW-1:0] BG_COLOR  = 8'h00,
  localparam int           BSW       = $clog2(BRUSH_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [XW-1:0]        in_x,
  input  logic [YW-1:0]        in_y,
  input  logic                 key_pal,
  input  logic                 key_enter,
  input  logic                 key_pal_ent,
  input  logic                 key_up,
  input  logic                 key_dn,
  input  logic                 key_erase,
  output logic                 kb_clr,
  output logic                 cursor_en,
  input  logic                 cursor_done,
  output logic                 pal_en,
  input  logic                 pal_done,
  input  logic [PAL_XW-1:0]    pal_x,
  input  logic [CW-PAL_XW-1:0] pal_y,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [XW-1:0]        wr_x,
  output logic [YW-1:0]        wr_y,
  output logic [CW-1:0]        wr_data,
  output logic [CW-1:0]        color,
  output logic [BSW-1:0]       brush_size,
  output logic                 erase,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_DECODE, S_PAINT, S_CURSOR, S_PALETTE, S_PAL_CHECK, S_SET_COLOR
  } state_t;

  localparam logic [BSW-1:0] BS_ONE = BSW'(1);
  localparam logic [BSW-1:0] BS_MAX = BSW'(BRUSH_MAX);
  localparam logic [XW:0]    X_LIM  = (XW+1)'(CANVAS_W);
  localparam logic [YW:0]    Y_LIM  = (YW+1)'(CANVAS_H);

  state_t         state;
  logic [XW-1:0]  cur_x;
  logic [YW-1:0]  cur_y;
  logic [BSW-1:0] dx, dy;

  logic [BSW-1:0] nx_dx, nx_dy;
  logic [XW:0]    nx_px;
  logic [YW:0]    nx_py;
  logic           nx_inb;
  logic           last_px;
  logic [BSW-1:0] size_nx;
  logic           erase_nx;

  // Enables and status are pure decodes of the current state.
  assign kb_clr    = (state == S_DECODE) || (state == S_PAL_CHECK);
  assign cursor_en = (state == S_CURSOR);
  assign pal_en    = (state == S_PALETTE);
  assign busy      = (state != S_IDLE);

  // Next brush offset and pixel address; computed one bit wider so the canvas
  // clip sees coordinates that run past the top of the XW/YW range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nx_dx   = '0;
    nx_dy   = '0;
    last_px = (dx == brush_size - BS_ONE) && (dy == brush_size - BS_ONE);
    if (state == S_PAINT) begin
      if (dx == brush_size - BS_ONE) begin
        nx_dx = '0;
        nx_dy = dy + BS_ONE;
      end else begin
        nx_dx = dx + BS_ONE;
        nx_dy = dy;
      end
    end
    nx_px  = {1'b0, cur_x} + (XW+1)'(nx_dx);
    nx_py  = {1'b0, cur_y} + (YW+1)'(nx_dy);
    nx_inb = (nx_px < X_LIM) && (nx_py < Y_LIM);
  end

  // Brush size / erase updates requested by the keys seen in DECODE.
  always_comb begin
    size_nx  = brush_size;
    erase_nx = erase ^ key_erase;
    if (key_up && !key_dn && (brush_size != BS_MAX))
      size_nx = brush_size + BS_ONE;
    else if (key_dn && !key_up && (brush_size != BS_ONE))
      size_nx = brush_size - BS_ONE;
  end

  // Controller FSM with registered write port, colour, brush and erase state.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here; state updates use non-blocking assignments so every
    // register sees pre-edge values.
    if (rst) begin
      state      <= S_IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      dx         <= '0;
      dy         <= '0;
      color      <= DEF_COLOR;
      brush_size <= BS_ONE;
      erase      <= 1'b0;
      wr_valid   <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_data    <= '0;
    end else begin
      case (state)
        S_IDLE: if (init) state <= S_SAMPLE;
        S_SAMPLE: begin
          cur_x <= in_x;
          cur_y <= in_y;
          state <= S_DECODE;
        end
        S_DECODE: begin
          brush_size <= size_nx;
          erase      <= erase_nx;
          if (key_pal) begin
            state <= S_PALETTE;
          end else if (key_enter) begin
            // Present the first brush pixel straight away; offsets start at 0.
            state    <= S_PAINT;
            dx       <= '0;
            dy       <= '0;
            wr_x     <= nx_px[XW-1:0];
            wr_y     <= nx_py[YW-1:0];
            wr_valid <= nx_inb;
            wr_data  <= erase_nx ? BG_COLOR : color;
          end else begin
            state <= S_CURSOR;
          end
        end
        S_PAINT: begin
          // A clipped pixel never raises valid, so it advances after one cycle.
          if (!wr_valid || wr_ready) begin
            if (last_px) begin
              wr_valid <= 1'b0;
              state    <= S_SAMPLE;
            end else begin
              dx       <= nx_dx;
              dy       <= nx_dy;
              wr_x     <= nx_px[XW-1:0];
              wr_y     <= nx_py[YW-1:0];
              wr_valid <= nx_inb;
            end
          end
        end
        S_CURSOR:  if (cursor_done) state <= S_SAMPLE;
        S_PALETTE: if (pal_done) state <= S_PAL_CHECK;
        S_PAL_CHECK: begin
          if (key_pal_ent)  state <= S_SET_COLOR;
          else if (key_pal) state <= S_SAMPLE;
          else              state <= S_PALETTE;
        end
        S_SET_COLOR: begin
          color <= {pal_y, pal_x};
          erase <= 1'b0;
          state <= S_SAMPLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
